spi_slave_param: RTL and testbench

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_tx_shift.sv | 29 ++
 rtl/spi_slave_param.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the parameterised SPI register slave.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    IDRD
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int cntWidth(input int hdrW, input int dataW);
    int maxW;
    maxW = (hdrW > dataW) ? hdrW : dataW;
    return $clog2(maxW + 1);
  endfunction

endpackage

// File: rtl/spi_tx_shift.sv
// Negedge MISO shifter: parallel load at word boundaries, MSb-first shift otherwise.
module spi_tx_shift #(
  parameter int DATA_W = 8
) (
  input  logic              SPI_SCLK,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              active_i,
  output logic              miso_o
);

  logic [DATA_W-1:0] sh_q;

  always_ff @(negedge SPI_SCLK or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (active_i) begin
      sh_q <= {sh_q[DATA_W-2:0], 1'b0};
    end else begin
      sh_q <= '0;
    end
  end

  assign miso_o = active_i & sh_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_param.sv
// SPI mode-0 register-access slave: header (R/W + address) followed by a burst
// of data words, with auto-increment inside a wrap window and a device-ID read.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int                ADDR_W  = 7,
  parameter int                DATA_W  = 8,
  parameter int                WRAP_LO = 7,
  parameter int                WRAP_HI = 11,
  parameter logic [DATA_W-1:0] DEV_ID  = '0
) (
  input  logic              SPI_SCLK,
  input  logic              rst_n,
  input  logic              SPI_SS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_data_ack,
  output logic              frame_err
);

  localparam int HDR_W = ADDR_W + 1;
  localparam int SW    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CW    = cntWidth(HDR_W, DATA_W);
  localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-2:0]     rx_q;
  logic [SW-1:0]     rx_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wrData_q;
  logic              pending_q;
  logic              valid_q;
  logic              ack_q;
  logic              frameErr_q;
  logic              load_q;

  logic              inHdr;
  logic              hdrDone;
  logic              wordDone;
  logic              hdrRw;
  logic [ADDR_W-1:0] hdrAddr;
  logic              isIdRead;
  logic              txActive;
  logic [DATA_W-1:0] txData;

  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    if ((WRAP_LO <= WRAP_HI) && (a == ADDR_W'(WRAP_HI))) return ADDR_W'(WRAP_LO);
    return a + ADDR_W'(1);
  endfunction

  always_comb begin
    rx_d     = {rx_q, SPI_MOSI};
    inHdr    = (state_q == IDLE) || (state_q == HDR);
    hdrDone  = !SPI_SS && inHdr && (cnt_q == HDR_LAST);
    wordDone = !SPI_SS && !inHdr && (cnt_q == DATA_LAST);
    hdrRw    = rx_d[HDR_W-1];
    hdrAddr  = rx_d[ADDR_W-1:0];
    isIdRead = (hdrRw == RW_READ) && (&hdrAddr);
  end

  // A completed write word is committed on the following edge whatever SS does;
  // writes advance addr after the strobe cycle, reads advance it on the ack edge
  // so the next negedge load already sees the new address.
  always_ff @(posedge SPI_SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      wrData_q   <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      frameErr_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      valid_q    <= pending_q;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      frameErr_q <= 1'b0;
      load_q     <= 1'b0;
      if (valid_q) addr_q <= nextAddr(addr_q);

      if (SPI_SS) begin
        frameErr_q <= (cnt_q != '0);
        cnt_q      <= '0;
        rx_q       <= '0;
        state_q    <= IDLE;
      end else begin
        rx_q  <= rx_d[SW-2:0];
        cnt_q <= cnt_q + CW'(1);
        case (state_q)
          IDLE, HDR: begin
            state_q <= HDR;
            if (hdrDone) begin
              cnt_q <= '0;
              if (hdrRw == RW_WRITE) begin
                state_q <= WDATA;
                addr_q  <= hdrAddr;
              end else if (isIdRead) begin
                state_q <= IDRD;
                load_q  <= 1'b1;
              end else begin
                state_q <= RDATA;
                addr_q  <= hdrAddr;
                load_q  <= 1'b1;
              end
            end
          end
          WDATA: begin
            if (wordDone) begin
              cnt_q     <= '0;
              wrData_q  <= rx_d[DATA_W-1:0];
              pending_q <= 1'b1;
            end
          end
          RDATA: begin
            if (wordDone) begin
              cnt_q  <= '0;
              ack_q  <= 1'b1;
              addr_q <= nextAddr(addr_q);
              load_q <= 1'b1;
            end
          end
          IDRD: begin
            if (wordDone) begin
              cnt_q  <= '0;
              load_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign txActive = (state_q == RDATA) || (state_q == IDRD);
  assign txData   = (state_q == IDRD) ? DEV_ID : rd_data;

  spi_tx_shift #(
    .DATA_W(DATA_W)
  ) uTxShift (
    .SPI_SCLK(SPI_SCLK),
    .rst_n   (rst_n),
    .load_i  (load_q),
    .data_i  (txData),
    .active_i(txActive),
    .miso_o  (SPI_MISO)
  );

  assign addr          = addr_q;
  assign wr_data       = wrData_q;
  assign wr_data_valid = valid_q;
  assign rd_data_ack   = ack_q;
  assign frame_err     = frameErr_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: directed frame table, reset/truncation sequences
// and random frames checked against a transaction-level model.
`timescale 1ns/1ps
module tb_spi_slave_param;

  logic       SPI_SCLK = 1'b0;
  logic       rst_n    = 1'b0;
  logic       SPI_SS   = 1'b1;
  logic       SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic       wr_data_valid;
  logic [7:0] rd_data;
  logic       rd_data_ack;
  logic       frame_err;
  logic [7:0] rdMask = 8'h00;

  int assertCount = 0;
  int failCount   = 0;

  logic [14:0] wrLog[$];
  int          ackCount  = 0;
  int          ferrCount = 0;

  logic [7:0]  rxWords[4];
  logic [14:0] expWr[$];
  logic [7:0]  expRd[4];

  typedef struct {
    logic [7:0]      hdr;
    int              nWords;
    int              partial;
    logic [3:0][7:0] words;
    int              nWr;
    logic [3:0][6:0] wrAddr;
    logic [3:0][7:0] wrData;
    logic [3:0][7:0] rdExp;
    int              acks;
    int              ferr;
    logic [6:0]      endAddr;
  } vec_t;

  always #5 SPI_SCLK = ~SPI_SCLK;

  // Register file stand-in: read data is the address, optionally scrambled
  assign rd_data = {1'b0, addr} ^ rdMask;

  spi_slave_param #(
    .ADDR_W (7),
    .DATA_W (8),
    .WRAP_LO(7),
    .WRAP_HI(11),
    .DEV_ID (8'h5C)
  ) dut (
    .SPI_SCLK     (SPI_SCLK),
    .rst_n        (rst_n),
    .SPI_SS       (SPI_SS),
    .SPI_MOSI     (SPI_MOSI),
    .SPI_MISO     (SPI_MISO),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_data_valid(wr_data_valid),
    .rd_data      (rd_data),
    .rd_data_ack  (rd_data_ack),
    .frame_err    (frame_err)
  );

  // Event monitor: every strobe is logged just after the edge that raised it
  always @(posedge SPI_SCLK) begin
    #1;
    if (wr_data_valid) wrLog.push_back({addr, wr_data});
    if (rd_data_ack) ackCount++;
    if (frame_err) ferrCount++;
  end

  function automatic logic [6:0] refNext(input logic [6:0] x);
    int y;
    y = (x == 7'd11) ? 7 : ((int'(x) + 1) % 128);
    return 7'(y);
  endfunction

  function automatic vec_t mkVec(input logic [7:0] hdr, input int nWords, input int partial,
                                 input logic [31:0] words, input int nWr, input logic [27:0] wrAddr,
                                 input logic [31:0] wrData, input logic [31:0] rdExp,
                                 input int acks, input int ferr, input logic [6:0] endAddr);
    vec_t v;
    v.hdr = hdr; v.nWords = nWords; v.partial = partial; v.words = words;
    v.nWr = nWr; v.wrAddr = wrAddr; v.wrData = wrData; v.rdExp = rdExp;
    v.acks = acks; v.ferr = ferr; v.endAddr = endAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input logic ss, input logic mosi, output logic miso);
    @(negedge SPI_SCLK);
    SPI_SS   = ss;
    SPI_MOSI = mosi;
    @(posedge SPI_SCLK);
    #1;
    miso = SPI_MISO;
  endtask

  task automatic applyStimulus(input logic [7:0] hdr, input int nWords, input int partial,
                               input logic [3:0][7:0] words);
    logic m;
    for (int i = 0; i < 4; i++) rxWords[i] = 8'h00;
    for (int i = 7; i >= 0; i--) tick(1'b0, hdr[i], m);
    for (int w = 0; w < nWords; w++) begin
      for (int b = 7; b >= 0; b--) begin
        tick(1'b0, words[w][b], m);
        rxWords[w][b] = m;
      end
    end
    for (int p = 0; p < partial; p++) tick(1'b0, 1'($urandom_range(0, 1)), m);
    tick(1'b1, 1'b0, m);
    tick(1'b1, 1'b0, m);
  endtask

  task automatic checkFrame(input string tag, input int nWords, input int wrBase, input int ackBase,
                            input int ferrBase, input int expAcks, input int expFerr,
                            input logic [6:0] expAddr);
    checkOutput({tag, " write count"}, 32'(wrLog.size() - wrBase), 32'(expWr.size()));
    for (int i = 0; i < expWr.size(); i++) begin
      if (wrBase + i < wrLog.size())
        checkOutput($sformatf("%s write %0d {addr,data}", tag, i), 32'(wrLog[wrBase + i]), 32'(expWr[i]));
    end
    for (int w = 0; w < nWords; w++)
      checkOutput($sformatf("%s miso word %0d", tag, w), 32'(rxWords[w]), 32'(expRd[w]));
    checkOutput({tag, " rd_data_ack pulses"}, 32'(ackCount - ackBase), 32'(expAcks));
    checkOutput({tag, " frame_err pulses"}, 32'(ferrCount - ferrBase), 32'(expFerr));
    checkOutput({tag, " final addr"}, 32'(addr), 32'(expAddr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " addr"}, 32'(addr), 32'h0);
    checkOutput({tag, " wr_data"}, 32'(wr_data), 32'h0);
    checkOutput({tag, " wr_data_valid"}, 32'(wr_data_valid), 32'h0);
    checkOutput({tag, " rd_data_ack"}, 32'(rd_data_ack), 32'h0);
    checkOutput({tag, " frame_err"}, 32'(frame_err), 32'h0);
    checkOutput({tag, " SPI_MISO"}, 32'(SPI_MISO), 32'h0);
  endtask

  initial begin
    vec_t            vecs[8];
    int              wrBase, ackBase, ferrBase, expAcks, expFerr;
    logic            m;
    logic [6:0]      mAddr, a;
    logic            rw;
    int              nW, partial, sel;
    logic [3:0][7:0] rWords;

    vecs[0] = mkVec(8'h85, 2, 0, 32'h0000_B2A1, 2, {7'h00, 7'h00, 7'h06, 7'h05}, 32'h0000_B2A1, 32'h0, 0, 0, 7'h07);
    vecs[1] = mkVec(8'h0A, 4, 0, 32'h0, 0, 28'h0, 32'h0, 32'h0807_0B0A, 4, 0, 7'h09);
    vecs[2] = mkVec(8'h7F, 1, 0, 32'h0, 0, 28'h0, 32'h0, 32'h0000_005C, 0, 0, 7'h09);
    vecs[3] = mkVec(8'h83, 0, 3, 32'h0, 0, 28'h0, 32'h0, 32'h0, 0, 1, 7'h03);
    vecs[4] = mkVec(8'hFF, 1, 0, 32'h0000_003C, 1, {21'h0, 7'h7F}, 32'h0000_003C, 32'h0, 0, 0, 7'h00);
    vecs[5] = mkVec(8'h8B, 2, 0, 32'h0000_2211, 2, {14'h0, 7'h07, 7'h0B}, 32'h0000_2211, 32'h0, 0, 0, 7'h08);
    vecs[6] = mkVec(8'h7E, 2, 0, 32'h0, 0, 28'h0, 32'h0, 32'h0000_7F7E, 2, 0, 7'h00);
    vecs[7] = mkVec(8'h05, 1, 5, 32'h0000_00C3, 0, 28'h0, 32'h0, 32'h0000_0005, 1, 1, 7'h06);

    #3;
    checkAllZero("reset");
    @(negedge SPI_SCLK);
    #1 rst_n = 1'b1;
    tick(1'b1, 1'b0, m);
    tick(1'b1, 1'b0, m);

    for (int v = 0; v < 8; v++) begin
      expWr.delete();
      for (int i = 0; i < vecs[v].nWr; i++) expWr.push_back({vecs[v].wrAddr[i], vecs[v].wrData[i]});
      for (int i = 0; i < 4; i++) expRd[i] = vecs[v].rdExp[i];
      wrBase = wrLog.size(); ackBase = ackCount; ferrBase = ferrCount;
      applyStimulus(vecs[v].hdr, vecs[v].nWords, vecs[v].partial, vecs[v].words);
      checkFrame($sformatf("vec%0d", v), vecs[v].nWords, wrBase, ackBase, ferrBase,
                 vecs[v].acks, vecs[v].ferr, vecs[v].endAddr);
    end

    // Reset asserted in the middle of a write word
    wrBase = wrLog.size(); ferrBase = ferrCount;
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'(8'h90 >> i), m);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, m);
    checkOutput("midword addr before reset", 32'(addr), 32'h10);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midword reset");
    SPI_SS = 1'b1;
    @(negedge SPI_SCLK);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, m);
    checkOutput("midword no strobe after reset", 32'(wrLog.size() - wrBase), 32'h0);
    checkOutput("midword no frame_err after reset", 32'(ferrCount - ferrBase), 32'h0);

    // Reset while a completed word is still waiting for its commit edge
    wrBase = wrLog.size();
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'(8'h91 >> i), m);
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'(8'h77 >> i), m);
    checkOutput("pending wr_data loaded", 32'(wr_data), 32'h77);
    checkOutput("pending no strobe yet", 32'(wr_data_valid), 32'h0);
    #2 rst_n = 1'b0;
    #1 checkOutput("pending wr_data cleared", 32'(wr_data), 32'h0);
    SPI_SS = 1'b1;
    @(negedge SPI_SCLK);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, m);
    checkOutput("pending write dropped", 32'(wrLog.size() - wrBase), 32'h0);
    checkOutput("pending addr after reset", 32'(addr), 32'h0);

    // Header truncated after five bits
    wrBase = wrLog.size(); ferrBase = ferrCount;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'(i % 2 == 0), m);
    tick(1'b1, 1'b0, m);
    tick(1'b1, 1'b0, m);
    checkOutput("short header frame_err", 32'(ferrCount - ferrBase), 32'h1);
    checkOutput("short header no write", 32'(wrLog.size() - wrBase), 32'h0);
    checkOutput("short header addr kept", 32'(addr), 32'h0);

    // Random frames against the transaction-level model
    rdMask = 8'($urandom);
    mAddr  = 7'h00;
    for (int n = 0; n < 30; n++) begin
      rw  = 1'($urandom_range(0, 1));
      a   = 7'($urandom_range(0, 127));
      sel = $urandom_range(0, 7);
      if (sel == 0) a = 7'h7F;
      else if (sel == 1) a = 7'($urandom_range(7, 11));
      nW      = $urandom_range(0, 3);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      rWords  = $urandom;

      expWr.delete();
      expAcks = 0;
      for (int i = 0; i < 4; i++) expRd[i] = 8'h00;
      if (rw) begin
        mAddr = a;
        for (int w = 0; w < nW; w++) begin
          expWr.push_back({mAddr, rWords[w]});
          mAddr = refNext(mAddr);
        end
      end else if (a == 7'h7F) begin
        for (int w = 0; w < nW; w++) expRd[w] = 8'h5C;
      end else begin
        mAddr = a;
        for (int w = 0; w < nW; w++) begin
          expRd[w] = {1'b0, mAddr} ^ rdMask;
          expAcks++;
          mAddr = refNext(mAddr);
        end
      end
      expFerr = (partial > 0) ? 1 : 0;

      wrBase = wrLog.size(); ackBase = ackCount; ferrBase = ferrCount;
      applyStimulus({rw, a}, nW, partial, rWords);
      checkFrame($sformatf("rand%0d hdr=%0h", n, {rw, a}), nW, wrBase, ackBase, ferrBase,
                 expAcks, expFerr, mAddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
